// File: rtl/gpio_wb_responder.sv
// GPIO register block behind a Wishbone slave: two-flop pad sync, byte-lane writes, single-cycle ack.
// Define GPIO_IRQ_EN to build IRQ_EN / IRQ_STAT / IRQ_POL, edge detection and irq_o; otherwise irq_o is 0.
module gpio_wb_responder #(
  parameter int GPIO_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  input  logic [GPIO_W-1:0] i_gpio,
  output logic [GPIO_W-1:0] o_gpio,
  output logic [GPIO_W-1:0] en_gpio,
  output logic              irq_o
);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  localparam logic [2:0] A_DIN  = 3'd0;
  localparam logic [2:0] A_DOUT = 3'd1;
  localparam logic [2:0] A_DIR  = 3'd2;
  localparam logic [2:0] A_IEN  = 3'd3;
  localparam logic [2:0] A_STAT = 3'd4;
  localparam logic [2:0] A_POL  = 3'd5;

  state_t            state_q, state_d;
  logic [31:0]       dat_q, dat_d;
  logic [GPIO_W-1:0] dout_q, dout_d;
  logic [GPIO_W-1:0] dir_q, dir_d;
  logic [GPIO_W-1:0] sync1_q, sync1_d;
  logic [GPIO_W-1:0] sync2_q, sync2_d;
  logic              req;
  logic              wr;
  logic [2:0]        rsel;
  logic [31:0]       bmask;
  logic              unused_adr;

  function automatic logic [31:0] ext(input logic [GPIO_W-1:0] v);
    logic [31:0] r;
    r = '0;
    r[GPIO_W-1:0] = v;
    return r;
  endfunction

  // Byte-lane merge; anything above GPIO_W is dropped by the truncating return.
  function automatic logic [GPIO_W-1:0] merge(input logic [GPIO_W-1:0] old,
                                              input logic [31:0] din,
                                              input logic [31:0] m);
    logic [31:0] r;
    r = (ext(old) & ~m) | (din & m);
    return r[GPIO_W-1:0];
  endfunction

  assign req        = (state_q == IDLE) && wb_cyc_i && wb_stb_i;
  assign wr         = req && wb_we_i;
  assign rsel       = wb_adr_i[4:2];
  assign bmask      = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign unused_adr = ^wb_adr_i[1:0];

`ifdef GPIO_IRQ_EN
  logic [GPIO_W-1:0] ien_q, ien_d;
  logic [GPIO_W-1:0] stat_q, stat_d;
  logic [GPIO_W-1:0] pol_q, pol_d;
  logic [GPIO_W-1:0] prev_q, prev_d;
  logic [GPIO_W-1:0] edge_det;
  logic [GPIO_W-1:0] w1c;
  logic              irq_q, irq_d;

  always_comb begin
    prev_d   = sync2_q;
    ien_d    = ien_q;
    pol_d    = pol_q;
    w1c      = '0;
    edge_det = (pol_q & sync2_q & ~prev_q) | (~pol_q & ~sync2_q & prev_q);
    if (wr) begin
      case (rsel)
        A_IEN:   ien_d = merge(ien_q, wb_dat_i, bmask);
        A_STAT:  w1c   = merge('0, wb_dat_i, bmask);
        A_POL:   pol_d = merge(pol_q, wb_dat_i, bmask);
        default: ;
      endcase
    end
    // Set is ORed in after the clear so a coincident edge survives the W1C.
    stat_d = (stat_q & ~w1c) | (edge_det & ien_q);
    irq_d  = |(stat_q & ien_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ien_q  <= '0;
      stat_q <= '0;
      pol_q  <= '0;
      prev_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ien_q  <= ien_d;
      stat_q <= stat_d;
      pol_q  <= pol_d;
      prev_q <= prev_d;
      irq_q  <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    dout_d  = dout_q;
    dir_d   = dir_q;
    sync1_d = i_gpio;
    sync2_d = sync1_q;
    case (state_q)
      IDLE:    if (wb_cyc_i && wb_stb_i) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (req) begin
      // Read data reflects register contents before this cycle's write commits.
      case (rsel)
        A_DIN:   dat_d = ext(sync2_q);
        A_DOUT:  dat_d = ext(dout_q);
        A_DIR:   dat_d = ext(dir_q);
`ifdef GPIO_IRQ_EN
        A_IEN:   dat_d = ext(ien_q);
        A_STAT:  dat_d = ext(stat_q);
        A_POL:   dat_d = ext(pol_q);
`endif
        default: dat_d = '0;
      endcase
    end
    if (wr) begin
      case (rsel)
        A_DOUT:  dout_d = merge(dout_q, wb_dat_i, bmask);
        A_DIR:   dir_d  = merge(dir_q, wb_dat_i, bmask);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dat_q   <= '0;
      dout_q  <= '0;
      dir_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign wb_ack_o = (state_q == ACK);
  assign wb_dat_o = dat_q;
  assign o_gpio   = dout_q;
  assign en_gpio  = dir_q;

endmodule

// File: tb/tb_gpio_wb_responder.sv
// Randomised bench for gpio_wb_responder: register-map reference model feeds a scoreboard drained on ack.
module tb_gpio_wb_responder;
  localparam int W = 32;
`ifdef GPIO_IRQ_EN
  localparam bit IRQB = 1'b1;
`else
  localparam bit IRQB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [4:0]    wb_adr_i;
  logic [3:0]    wb_sel_i;
  logic [31:0]   wb_dat_i, wb_dat_o;
  logic          wb_ack_o;
  logic [W-1:0]  i_gpio, o_gpio, en_gpio;
  logic          irq_o;

  gpio_wb_responder #(.GPIO_W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .i_gpio(i_gpio), .o_gpio(o_gpio), .en_gpio(en_gpio), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_rd;
    logic [31:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Architectural register state as seen by software.
  logic [31:0] m_dout, m_dir, m_ien, m_stat, m_pol, m_pad;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{s[b]}};
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a[4:2])
      3'd0: return m_pad;
      3'd1: return m_dout;
      3'd2: return m_dir;
      3'd3: return IRQB ? m_ien  : 32'd0;
      3'd4: return IRQB ? m_stat : 32'd0;
      3'd5: return IRQB ? m_pol  : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = lanes(s);
    case (a[4:2])
      3'd1: m_dout = (m_dout & ~m) | (d & m);
      3'd2: m_dir  = (m_dir  & ~m) | (d & m);
      3'd3: if (IRQB) m_ien = (m_ien & ~m) | (d & m);
      3'd4: if (IRQB) m_stat = m_stat & ~(d & m);
      3'd5: if (IRQB) m_pol = (m_pol & ~m) | (d & m);
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_dout = 0; m_dir = 0; m_ien = 0; m_stat = 0; m_pol = 0;
  endtask

  task automatic check_pins(input string tag);
    check({tag, "_o_gpio"}, o_gpio, m_dout);
    check({tag, "_en_gpio"}, en_gpio, m_dir);
    check({tag, "_irq"}, {31'd0, irq_o}, {31'd0, |(m_stat & m_ien)});
  endtask

  // Scoreboard monitor: every ack consumes one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && wb_ack_o === 1'b1) begin
      if (sbq.size() == 0) check("unexpected_ack", {31'd0, wb_ack_o}, 32'd0);
      else begin
        e = sbq.pop_front();
        if (e.is_rd) check("read_data", wb_dat_o, e.exp);
      end
    end
  end

  task automatic bus(input bit we, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    @(negedge clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
    e.is_rd = !we;
    e.exp   = model_read(a);
    sbq.push_back(e);
    if (we) model_write(a, d, s);
    @(negedge clk);
    check("ack_one_cycle", {31'd0, wb_ack_o}, 32'd1);
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    @(negedge clk);
    check("ack_single", {31'd0, wb_ack_o}, 32'd0);
    check_pins("post_bus");
  endtask

  // Pad change; edge flags follow from old/new pad values under current IRQ_EN/IRQ_POL.
  task automatic pad(input logic [31:0] v, input int settle);
    logic [31:0] rise, fall;
    @(negedge clk);
    i_gpio = v;
    rise = v & ~m_pad;
    fall = ~v & m_pad;
    if (IRQB) m_stat = m_stat | (m_ien & ((m_pol & rise) | (~m_pol & fall)));
    m_pad = v;
    repeat (settle) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    reset_n = 0;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_sel_i = 0; wb_dat_i = 0;
    i_gpio = 0;
    m_pad = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check_pins("rst");
    reset_n = 1;
    repeat (2) @(negedge clk);

    // Full-word write then read back.
    bus(1, 5'h04, 32'hA5A5A5A5, 4'b1111);
    check("a5_o_gpio", o_gpio, 32'hA5A5A5A5);
    bus(0, 5'h04, 0, 4'b0000);

    // Single byte lane.
    bus(1, 5'h04, 32'hFFFFFFFF, 4'b1111);
    bus(1, 5'h04, 32'h00000000, 4'b0010);
    check("lane_o_gpio", o_gpio, 32'hFFFF00FF);

    // Pad sync: read issued three cycles after the pad change.
    pad(32'h5A5A5A5A, 2);
    bus(0, 5'h00, 0, 4'b0000);
    bus(0, 5'h1C, 0, 4'b0000);

`ifdef GPIO_IRQ_EN
    bus(1, 5'h0C, 32'h1, 4'b1111);
    bus(1, 5'h14, 32'h1, 4'b1111);
    pad(32'h5A5A5A5B, 5);
    check("irq_rise", {31'd0, irq_o}, 32'd1);
    bus(0, 5'h10, 0, 4'b0000);
    bus(1, 5'h10, 32'h1, 4'b1111);
    check("irq_w1c", {31'd0, irq_o}, 32'd0);
    // Disabling IRQ_EN keeps status but drops irq_o.
    pad(32'h5A5A5A5A, 5);
    pad(32'h5A5A5A5B, 5);
    bus(1, 5'h0C, 32'h0, 4'b1111);
    check("irq_en_off", {31'd0, irq_o}, 32'd0);
    bus(0, 5'h10, 0, 4'b0000);
`else
    bus(1, 5'h0C, 32'hFFFFFFFF, 4'b1111);
    pad(32'hA5A5A5A5, 5);
    pad(32'h5A5A5A5A, 5);
    bus(0, 5'h0C, 0, 4'b0000);
    check("noirq_irq", {31'd0, irq_o}, 32'd0);
`endif

    // Strobe withdrawn before sampling: no ack, no write.
    @(negedge clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 5'h04; wb_dat_i = ~m_dout; wb_sel_i = 4'hF;
    #2;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    repeat (2) begin
      @(negedge clk);
      check("drop_no_ack", {31'd0, wb_ack_o}, 32'd0);
    end
    check("drop_no_write", o_gpio, m_dout);

    // Strobe held for four cycles, then reset while in ACK.
    @(negedge clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 5'h04;
    sbq.push_back('{1'b1, m_dout});
    sbq.push_back('{1'b1, m_dout});
    check("hold_ack0", {31'd0, wb_ack_o}, 32'd0);
    @(negedge clk); check("hold_ack1", {31'd0, wb_ack_o}, 32'd1);
    @(negedge clk); check("hold_ack2", {31'd0, wb_ack_o}, 32'd0);
    @(negedge clk); check("hold_ack3", {31'd0, wb_ack_o}, 32'd1);
    #1 reset_n = 0;
    #1;
    model_reset();
    check("rst_mid_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_mid_o_gpio", o_gpio, 32'd0);
    check("rst_mid_irq", {31'd0, irq_o}, 32'd0);
    @(negedge clk);
    wb_cyc_i = 0; wb_stb_i = 0;
    @(negedge clk);
    reset_n = 1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_ack", {31'd0, wb_ack_o}, 32'd0);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 2))
        0: bus(1, {3'($urandom_range(0, 7)), 2'($urandom)}, $urandom, 4'($urandom));
        1: bus(0, {3'($urandom_range(0, 7)), 2'($urandom)}, $urandom, 4'($urandom));
        default: begin
          v = ($urandom_range(0, 1) == 0) ? $urandom : (m_pad ^ (32'd1 << $urandom_range(0, 31)));
          pad(v, 5);
          check_pins("post_pad");
        end
      endcase
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_wb_responder.md
GPIO_WB_RESPONDER -- requirements
Module: gpio_wb_responder

Interface
REQ-001 SHALL have parameter GPIO_W, default 32, number of GPIO pins (1..32).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port wb_cyc_i  input  1  bus cycle valid.
REQ-005 SHALL have port wb_stb_i  input  1  strobe, request present.
REQ-006 SHALL have port wb_we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port wb_adr_i  input  5  byte address; bits [4:2] select register, [1:0] ignored.
REQ-008 SHALL have port wb_sel_i  input  4  byte lane enables for writes.
REQ-009 SHALL have port wb_dat_i  input  32  write data.
REQ-010 SHALL have port wb_dat_o  output  32  read data, valid while wb_ack_o=1.
REQ-011 SHALL have port wb_ack_o  output  1  single-cycle acknowledge.
REQ-012 SHALL have port i_gpio  input  GPIO_W  asynchronous pad inputs.
REQ-013 SHALL have port o_gpio  output  GPIO_W  pad output values.
REQ-014 SHALL have port en_gpio  output  GPIO_W  per-pin output enable, 1 = drive.
REQ-015 SHALL have port irq_o  output  1  level interrupt request.

Function
REQ-016 SHALL map registers: 0x00 DATA_IN (RO), 0x04 DATA_OUT (RW), 0x08 DIR (RW), 0x0C IRQ_EN (RW), 0x10 IRQ_STAT (RW1C), 0x14 IRQ_POL (RW, 1 = rising, 0 = falling).
REQ-017 SHALL use a two-state handshake FSM: IDLE -> ACK when wb_cyc_i&wb_stb_i; ACK -> IDLE unconditionally; wb_ack_o=1 only in ACK.
REQ-018 SHALL acknowledge every request exactly one cycle after first sampling it; back-to-back requests SHALL give ack every other cycle.
REQ-019 SHALL commit writes in the IDLE->ACK cycle, byte lanes gated by wb_sel_i; bits at or above GPIO_W SHALL be ignored.
REQ-020 SHALL register read data in the IDLE->ACK cycle; unused upper bits and unmapped addresses SHALL read 0.
REQ-021 SHALL acknowledge unmapped addresses and discard their writes without error.
REQ-022 SHALL drop a request whose wb_stb_i or wb_cyc_i falls before sampling; no ack, no side effect.
REQ-023 SHALL synchronise i_gpio through two flops; DATA_IN returns the second flop (2-3 cycle latency from pad).
REQ-024 SHALL drive o_gpio=DATA_OUT and en_gpio=DIR directly from registers.
REQ-025 SHALL detect edges by comparing synchronised input with its one-cycle-delayed copy, per IRQ_POL.
REQ-026 SHALL set IRQ_STAT[n] on a detected edge when IRQ_EN[n]=1; when set and W1C coincide, set SHALL win.
REQ-027 SHALL register irq_o = |(IRQ_STAT & IRQ_EN), one cycle after the status change.
REQ-028 SHALL leave IRQ_STAT unchanged when IRQ_EN is cleared; irq_o SHALL then deassert.

Reset
REQ-029 SHALL, on reset_n=0, immediately clear FSM to IDLE, wb_ack_o, wb_dat_o, o_gpio, en_gpio, irq_o, all registers and sync flops to 0.
REQ-030 SHALL discard any request in flight when reset asserts mid-transaction; no ack after release until a new request is sampled.
REQ-031 SHALL not flag edges on the first cycles after release (delayed copy reset to 0 equals sync value 0).

Configuration
REQ-032 SHALL, with GPIO_IRQ_EN defined, implement IRQ_EN, IRQ_STAT, IRQ_POL, edge detection and irq_o per REQ-025..028.
REQ-033 SHALL, without GPIO_IRQ_EN, omit that logic: 0x0C-0x14 read 0, writes ignored but acknowledged, irq_o tied 0.

Verification
REQ-034 SHALL test: write 0x04 = 0xA5A5A5A5, sel=4'b1111 -> ack one cycle later, o_gpio=0xA5A5A5A5; read 0x04 returns it.
REQ-035 SHALL test: DATA_OUT=0xFFFFFFFF, write 0x04 = 0x00000000 sel=4'b0010 -> o_gpio=0xFFFF00FF.
REQ-036 SHALL test: i_gpio=0x5A5A5A5A -> read 0x00 issued 3 cycles later returns 0x5A5A5A5A; read 0x1C returns 0.
REQ-037 SHALL test (GPIO_IRQ_EN): IRQ_EN=0x1, IRQ_POL=0x1, i_gpio[0] 0->1 -> IRQ_STAT=0x1, irq_o=1; write 0x10=0x1 -> irq_o=0 next cycle.
REQ-038 SHALL test: stb held high 4 cycles -> ack pattern 0,1,0,1; reset_n pulsed low while in ACK -> ack drops immediately, o_gpio=0.
REQ-039 SHALL test (no GPIO_IRQ_EN): write 0x0C=0xFFFFFFFF, toggle i_gpio -> ack received, read 0x0C=0, irq_o stays 0.
